serial_word_feeder: RTL and testbench

// - Upstream driver for the serial mod-N divisibility checkers: takes a W-bit word on a

---
 rtl/serial_word_feeder.sv | 111 +++++++++++
 tb/tb_serial_word_feeder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/serial_word_feeder.sv
// Streams a W-bit word MSB-first into a serial divisibility checker and returns its verdict.
// Optional: define SERIAL_WORD_FEEDER_ECHO_EN to add a res_word port echoing the word under test.
module serial_word_feeder #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_word,
    output logic         chk_clr,
    output logic         ser_bit,
    input  logic         div_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         res_div
`ifdef SERIAL_WORD_FEEDER_ECHO_EN
    ,
    output logic [W-1:0] res_word
`endif
);

    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {StIdle, StShift, StCapture, StResp} state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    shreg_q, shreg_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            res_div_q, res_div_d;
`ifdef SERIAL_WORD_FEEDER_ECHO_EN
    logic [W-1:0]    word_q, word_d;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            shreg_q   <= '0;
            cnt_q     <= '0;
            res_div_q <= 1'b0;
`ifdef SERIAL_WORD_FEEDER_ECHO_EN
            word_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            res_div_q <= res_div_d;
`ifdef SERIAL_WORD_FEEDER_ECHO_EN
            word_q    <= word_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        res_div_d = res_div_q;
`ifdef SERIAL_WORD_FEEDER_ECHO_EN
        word_d    = word_q;
`endif
        in_ready  = 1'b0;
        chk_clr   = 1'b1;
        ser_bit   = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            StIdle: begin
                // Gate with rst so no handshake is advertised while held in reset.
                in_ready = rst;
                if (in_valid) begin
                    state_d = StShift;
                    shreg_d = in_word;
                    cnt_d   = CW'(W - 1);
`ifdef SERIAL_WORD_FEEDER_ECHO_EN
                    word_d  = in_word;
`endif
                end
            end
            StShift: begin
                chk_clr = 1'b0;
                ser_bit = shreg_q[W-1];
                shreg_d = shreg_q << 1;
                if (cnt_q == '0) begin
                    state_d = StCapture;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            StCapture: begin
                // div_in is sampled pre-edge, while chk_clr clears the checker at that same edge.
                res_div_d = div_in;
                state_d   = StResp;
            end
            StResp: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign res_div = res_div_q;
`ifdef SERIAL_WORD_FEEDER_ECHO_EN
    assign res_word = word_q;
`endif

endmodule

// File: tb/tb_serial_word_feeder.sv
// Bench for serial_word_feeder driving a behavioural divisible-by-5 serial checker.
// Expected verdicts are queued at acceptance and popped at the result handshake.
module tb_serial_word_feeder;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_word = '0;
    logic         chk_clr;
    logic         ser_bit;
    logic         div_in;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         res_div;
`ifdef SERIAL_WORD_FEEDER_ECHO_EN
    logic [W-1:0] res_word;
`endif

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    logic [W:0] sb_q[$];
    logic [2:0] mod_q = 3'd0;

    serial_word_feeder #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
        .chk_clr   (chk_clr),
        .ser_bit   (ser_bit),
        .div_in    (div_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res_div   (res_div)
`ifdef SERIAL_WORD_FEEDER_ECHO_EN
        ,
        .res_word  (res_word)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Serial mod-5 checker: registered remainder, sync clear, flag compares the register.
    always @(posedge clk) begin
        if (chk_clr) mod_q <= 3'd0;
        else         mod_q <= 3'(({29'd0, mod_q} * 2 + {31'd0, ser_bit}) % 5);
    end
    assign div_in = (mod_q == 3'd0);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_word(input logic [W-1:0] w, input int hold, input bit keep_valid,
                            input logic [W-1:0] nxt, output int acc_cyc, output int hs_cyc);
        int waited = 0;
        logic rd0;
        logic [W:0] e;
        acc_cyc = -1;
        hs_cyc = -1;
        @(negedge clk);
        while (in_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk("in_ready_idle", in_ready, 1);
        if (in_ready !== 1'b1) return;
        in_valid = 1'b1;
        in_word = w;
        out_ready = (hold == 0);
        @(posedge clk);
        acc_cyc = cyc;
        sb_q.push_back({(w % 8'd5) == 8'd0, w});
        for (int k = 1; k <= int'(W); k++) begin
            @(negedge clk);
            chk("ser_bit", ser_bit, w[W-k]);
            chk("chk_clr_shift", chk_clr, 0);
            if (k == 1) begin
                chk("in_ready_shift", in_ready, 0);
                in_valid = keep_valid;
                in_word = nxt;
            end
        end
        @(negedge clk);
        chk("capture_no_valid", out_valid, 0);
        chk("chk_clr_capture", chk_clr, 1);
        chk("ser_bit_capture", ser_bit, 0);
        @(negedge clk);
        chk("latency_out_valid", out_valid, 1);
        rd0 = res_div;
        for (int h = 0; h < hold; h++) begin
            chk("bp_out_valid", out_valid, 1);
            chk("bp_res_div", res_div, rd0);
            chk("bp_in_ready", in_ready, 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        chk("resp_out_valid", out_valid, 1);
        chk("resp_chk_clr", chk_clr, 1);
        if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 0, 1);
        end else begin
            e = sb_q.pop_front();
            chk("res_div", res_div, e[W]);
`ifdef SERIAL_WORD_FEEDER_ECHO_EN
            chk("res_word", res_word, e[W-1:0]);
`endif
        end
        @(posedge clk);
        hs_cyc = cyc;
    endtask

    initial begin
        int a0, h0, a1, h1, a2, h2, seen;
        #1 rst = 1'b0;
        #1;
        chk("rst_chk_clr", chk_clr, 1);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_ser_bit", ser_bit, 0);
        chk("rst_res_div", res_div, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        run_word(8'd15, 0, 1'b0, 8'd0, a0, h0);
        run_word(8'd7, 0, 1'b0, 8'd0, a0, h0);
        run_word(8'd0, 0, 1'b0, 8'd0, a0, h0);
        run_word(8'd255, 0, 1'b0, 8'd0, a0, h0);
        run_word(8'd128, 0, 1'b0, 8'd0, a0, h0);
        run_word(8'd42, 0, 1'b0, 8'd0, a0, h0);

        // Back-pressure with a pending word, then back-to-back 10 and 11.
        run_word(8'd33, 5, 1'b1, 8'd10, a0, h0);
        run_word(8'd10, 0, 1'b1, 8'd11, a1, h1);
        run_word(8'd11, 0, 1'b0, 8'd0, a2, h2);
        chk("accept_after_hs", a1 - h0, 1);
        chk("b2b_spacing", a2 - a1, 11);

        // Reset in the 4th SHIFT cycle drops the word.
        @(negedge clk);
        in_valid = 1'b1;
        in_word = 8'd99;
        @(posedge clk);
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        #1 rst = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_chk_clr", chk_clr, 1);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_ser_bit", ser_bit, 0);
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen++;
        end
        chk("midrst_no_result", seen, 0);
        run_word(8'd20, 0, 1'b0, 8'd0, a0, h0);

        chk("scoreboard_drained", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
